// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the modular exponentiation engine.
package rsa_pkg;

   localparam int WIDTH_DEF     = 6;
   localparam int MODULUS_DEF   = 63;
   localparam int EXP_WIDTH_DEF = 6;

   localparam int ONE = 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL_A,
      RED_A,
      MUL_B,
      RED_B
   } state_t;

endpackage

// File: rtl/mod_reduce.sv
// Combinational x mod MODULUS over a double-width product; output is always < MODULUS.
module mod_reduce
   import rsa_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int MODULUS = MODULUS_DEF
) (
   input  logic [2*WIDTH-1:0] x,
   output logic [WIDTH-1:0]   y
);

   localparam logic [2*WIDTH-1:0] MOD_EXT = (2*WIDTH)'(MODULUS);

   // The remainder is strictly below MODULUS < 2**WIDTH, so truncation loses nothing.
   assign y = WIDTH'(x % MOD_EXT);

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply: result = base^exponent mod MODULUS.
// Each exponent bit costs four cycles (multiply, reduce, square, reduce);
// one shared reducer serves LOAD, RED_A and RED_B.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// LOAD  | reduce base into b, acc=1, cnt=0
// MUL_A | prod = acc * (e[0] ? b : 1)
// RED_A | acc = prod mod N
// MUL_B | prod = b * b
// RED_B | b = prod mod N, shift e, count bit; finish after last bit
module mod_exp_engine
   import rsa_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MODULUS   = MODULUS_DEF,
   parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     base,
   input  logic [EXP_WIDTH-1:0] exponent,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result
);

   localparam int CW = $clog2(EXP_WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   state_t               state, state_nx;
   logic [WIDTH-1:0]     temp;
   logic [EXP_WIDTH-1:0] e_reg;
   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     b;
   logic [PW-1:0]        prod;
   logic [CW-1:0]        cnt;
   logic [PW-1:0]        red_in;
   logic [WIDTH-1:0]     red_out;
   logic [WIDTH-1:0]     mul_op;
   logic                 last_bit;

   assign last_bit = (cnt == CW'(EXP_WIDTH - 1));
   assign mul_op   = e_reg[0] ? b : WIDTH'(ONE);

   mod_reduce #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_reduce (
      .x (red_in),
      .y (red_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state sequencing and reducer input select.
   always_comb begin
      state_nx = state;
      red_in   = prod;
      case (state)
         IDLE:  if (start) state_nx = LOAD;
         LOAD: begin
            red_in   = {{WIDTH{1'b0}}, temp};
            state_nx = MUL_A;
         end
         MUL_A: state_nx = RED_A;
         RED_A: state_nx = MUL_B;
         MUL_B: state_nx = RED_B;
         RED_B: state_nx = last_bit ? IDLE : MUL_A;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and handshake registers; done is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         temp   <= '0;
         e_reg  <= '0;
         acc    <= '0;
         b      <= '0;
         prod   <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  temp  <= base;
                  e_reg <= exponent;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               b   <= red_out;
               acc <= WIDTH'(ONE);
               cnt <= '0;
            end
            MUL_A: prod <= PW'(acc) * PW'(mul_op);
            RED_A: acc  <= red_out;
            MUL_B: prod <= PW'(b) * PW'(b);
            RED_B: begin
               b     <= red_out;
               e_reg <= e_reg >> 1;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  result <= acc;
                  done   <= 1'b1;
                  busy   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed scoreboard bench for mod_exp_engine (N = 63, 6-bit operands and exponent).
module tb_mod_exp_engine;
   import rsa_pkg::*;

   localparam int W  = 6;
   localparam int EW = 6;
   localparam int LAT = 26;  // negedge of issue -> negedge where done is seen

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  base = '0;
   logic [EW-1:0] exponent = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int res;
      int due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   mod_exp_engine #(
      .WIDTH     (W),
      .MODULUS   (63),
      .EXP_WIDTH (EW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base     (base),
      .exponent (exponent),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", 32'(result), 32'(mon_e.res));
            check("latency", 32'(cyc), 32'(mon_e.due));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // Called at a negedge; start is sampled at the following posedge.
   task automatic issue(input int b, input int e, input int res, input bit track);
      start    = 1'b1;
      base     = W'(b);
      exponent = EW'(e);
      if (track) exp_q.push_back('{res, cyc + LAT});
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int max);
      int n;
      n = 0;
      while (!done && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // 5^3 = 125 mod 63 = 62
      issue(5, 3, 62, 1'b1);
      wait_done(40);
      @(negedge clk);

      // 2^6 = 64 mod 63 = 1, then 10^63 mod 63 = 55 started in the done cycle
      issue(2, 6, 1, 1'b1);
      wait_done(40);
      issue(10, 63, 55, 1'b1);
      wait_done(40);
      @(negedge clk);

      issue(17, 0, 1, 1'b1);
      wait_done(40);
      @(negedge clk);
      issue(0, 0, 1, 1'b1);
      wait_done(40);
      @(negedge clk);
      issue(63, 5, 0, 1'b1);
      wait_done(40);
      @(negedge clk);

      // start while busy is ignored; result stays 5^3 mod 63
      issue(5, 3, 62, 1'b1);
      repeat (4) @(negedge clk);
      start    = 1'b1;
      base     = W'(9);
      exponent = EW'(2);
      @(negedge clk);
      start = 1'b0;
      check("busy_during_run", 32'(busy), 32'd1);
      wait_done(40);
      @(negedge clk);

      // reset mid-run abandons the computation
      issue(5, 3, 0, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      repeat (30) @(negedge clk);

      // 3^4 = 81 mod 63 = 18
      issue(3, 4, 18, 1'b1);
      wait_done(40);
      repeat (3) @(negedge clk);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
